// File: rtl/mem_io_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mem_io_sequencer
// Purpose  : Load / run / dump sequencer for the multicore data memory.
//            Streams LOAD_WORDS host words into memory, starts all cores,
//            waits for every core to finish, then streams DUMP_WORDS words
//            from DUMP_BASE out to a sink. Owns the memory mux select.
// Options  : MEM_IO_CHECKSUM_EN adds a running sum of dumped words.
// Revision : 1.0 - initial release
// ============================================================================
module mem_io_sequencer #(
   parameter int DATA_W     = 16,
   parameter int ADDR_W     = 16,
   parameter int LOAD_WORDS = 1000,
   parameter int DUMP_BASE  = 0,
   parameter int DUMP_WORDS = 997,
   parameter int NUM_CORES  = 4,
   parameter int RD_LAT     = 1
) (
   input  logic                 clk,
   input  logic                 RESET,
   input  logic                 go,
   input  logic                 din_valid,
   output logic                 din_ready,
   input  logic [DATA_W-1:0]    din_data,
   output logic [1:0]           mem_sel,
   output logic [ADDR_W-1:0]    mem_addr,
   output logic [DATA_W-1:0]    mem_wdata,
   output logic                 mem_we,
   input  logic [DATA_W-1:0]    mem_rdata,
   output logic [NUM_CORES-1:0] core_start,
   input  logic [NUM_CORES-1:0] core_end,
   output logic                 dout_valid,
   input  logic                 dout_ready,
   output logic [DATA_W-1:0]    dout_data,
   output logic                 busy,
   output logic                 done,
   output logic [2:0]           state_disp
`ifdef MEM_IO_CHECKSUM_EN
   ,
   output logic [DATA_W-1:0]    checksum,
   output logic                 checksum_valid
`endif
);

   // Counters are one bit wider than the address so a full 2^ADDR_W load fits.
   localparam int CNT_W  = ADDR_W + 1;
   localparam int WAIT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

   localparam logic [CNT_W-1:0]  LOAD_CNT_END = CNT_W'(LOAD_WORDS);
   localparam logic [CNT_W-1:0]  DUMP_CNT_END = CNT_W'(DUMP_WORDS);
   localparam logic [ADDR_W-1:0] DUMP_BASE_A  = ADDR_W'(DUMP_BASE);
   localparam logic [WAIT_W-1:0] WAIT_LAST    = WAIT_W'(RD_LAT - 1);

   localparam logic [1:0] SEL_CORES  = 2'd0;
   localparam logic [1:0] SEL_LOADER = 2'd1;
   localparam logic [1:0] SEL_DUMPER = 2'd2;

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_LOAD      = 3'd1;
   localparam logic [2:0] S_RUN       = 3'd2;
   localparam logic [2:0] S_WAIT_END  = 3'd3;
   localparam logic [2:0] S_DUMP_ADDR = 3'd4;
   localparam logic [2:0] S_DUMP_WAIT = 3'd5;
   localparam logic [2:0] S_DUMP_OUT  = 3'd6;
   localparam logic [2:0] S_DONE      = 3'd7;

   logic [2:0]           state_q,      state_d;
   logic [1:0]           mem_sel_q,    mem_sel_d;
   logic [CNT_W-1:0]     load_cnt_q,   load_cnt_d;
   logic [CNT_W-1:0]     dump_cnt_q,   dump_cnt_d;
   logic [WAIT_W-1:0]    wait_cnt_q,   wait_cnt_d;
   logic [NUM_CORES-1:0] end_flags_q,  end_flags_d;
   logic [NUM_CORES-1:0] core_start_q, core_start_d;
   logic                 mem_we_q,     mem_we_d;
   logic [ADDR_W-1:0]    mem_addr_q,   mem_addr_d;
   logic [DATA_W-1:0]    mem_wdata_q,  mem_wdata_d;
   logic [DATA_W-1:0]    dout_data_q,  dout_data_d;

   logic                 w_idle_or_done;
   logic                 w_din_hs;
   logic [NUM_CORES-1:0] w_flags_all;
   logic [CNT_W-1:0]     w_dump_cnt_inc;

   assign w_idle_or_done = (state_q == S_IDLE) || (state_q == S_DONE);
   assign din_ready      = (state_q == S_LOAD) && (load_cnt_q != LOAD_CNT_END);
   assign w_din_hs       = din_valid && din_ready;
   // An end pulse coinciding with core_start (RUN) must still be captured.
   assign w_flags_all    = end_flags_q | core_end;
   assign w_dump_cnt_inc = dump_cnt_q + 1'b1;

   assign dout_valid = (state_q == S_DUMP_OUT);
   assign busy       = !w_idle_or_done;
   assign done       = (state_q == S_DONE);
   assign state_disp = state_q;
   assign mem_sel    = mem_sel_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;
   assign mem_we     = mem_we_q;
   assign core_start = core_start_q;
   assign dout_data  = dout_data_q;

   // Next-state logic for the sequencer FSM and its datapath registers.
   always_comb begin
      state_d      = state_q;
      mem_sel_d    = mem_sel_q;
      load_cnt_d   = load_cnt_q;
      dump_cnt_d   = dump_cnt_q;
      wait_cnt_d   = wait_cnt_q;
      end_flags_d  = end_flags_q;
      core_start_d = '0;
      mem_we_d     = 1'b0;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      dout_data_d  = dout_data_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (go) begin
               state_d     = S_LOAD;
               mem_sel_d   = SEL_LOADER;
               load_cnt_d  = '0;
               dump_cnt_d  = '0;
               end_flags_d = '0;
            end
         end
         S_LOAD: begin
            if (w_din_hs) begin
               // Write is registered: it appears on the memory port next cycle.
               mem_we_d    = 1'b1;
               mem_addr_d  = load_cnt_q[ADDR_W-1:0];
               mem_wdata_d = din_data;
               load_cnt_d  = load_cnt_q + 1'b1;
            end else if (load_cnt_q == LOAD_CNT_END) begin
               // The final write is on the port this cycle; leave once it lands.
               state_d      = S_RUN;
               mem_sel_d    = SEL_CORES;
               core_start_d = '1;
            end
         end
         S_RUN: begin
            end_flags_d = w_flags_all;
            state_d     = S_WAIT_END;
         end
         S_WAIT_END: begin
            end_flags_d = w_flags_all;
            if (&w_flags_all) begin
               state_d    = S_DUMP_ADDR;
               mem_sel_d  = SEL_DUMPER;
               mem_addr_d = DUMP_BASE_A + dump_cnt_q[ADDR_W-1:0];
            end
         end
         S_DUMP_ADDR: begin
            wait_cnt_d = '0;
            state_d    = S_DUMP_WAIT;
         end
         S_DUMP_WAIT: begin
            if (wait_cnt_q == WAIT_LAST) begin
               dout_data_d = mem_rdata;
               state_d     = S_DUMP_OUT;
            end else begin
               wait_cnt_d = wait_cnt_q + 1'b1;
            end
         end
         S_DUMP_OUT: begin
            if (dout_ready) begin
               dump_cnt_d = w_dump_cnt_inc;
               if (w_dump_cnt_inc == DUMP_CNT_END) begin
                  state_d   = S_DONE;
                  mem_sel_d = SEL_CORES;
               end else begin
                  state_d    = S_DUMP_ADDR;
                  mem_addr_d = DUMP_BASE_A + w_dump_cnt_inc[ADDR_W-1:0];
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers; reset abandons any partial load or dump.
   always_ff @(posedge clk or negedge RESET) begin
      if (!RESET) begin
         state_q      <= S_IDLE;
         mem_sel_q    <= SEL_CORES;
         load_cnt_q   <= '0;
         dump_cnt_q   <= '0;
         wait_cnt_q   <= '0;
         end_flags_q  <= '0;
         core_start_q <= '0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         dout_data_q  <= '0;
      end else begin
         state_q      <= state_d;
         mem_sel_q    <= mem_sel_d;
         load_cnt_q   <= load_cnt_d;
         dump_cnt_q   <= dump_cnt_d;
         wait_cnt_q   <= wait_cnt_d;
         end_flags_q  <= end_flags_d;
         core_start_q <= core_start_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         dout_data_q  <= dout_data_d;
      end
   end

`ifdef MEM_IO_CHECKSUM_EN
   logic [DATA_W-1:0] checksum_q;

   assign checksum       = checksum_q;
   assign checksum_valid = (state_q == S_DONE);

   // Running modulo-2^DATA_W sum of every word accepted by the sink.
   always_ff @(posedge clk or negedge RESET) begin
      if (!RESET) begin
         checksum_q <= '0;
      end else if (w_idle_or_done && go) begin
         checksum_q <= '0;
      end else if (dout_valid && dout_ready) begin
         checksum_q <= checksum_q + dout_data_q;
      end
   end
`else
   // No checksum logic in this build.
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_io_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_io_sequencer
// Purpose  : Self-checking bench for mem_io_sequencer with a behavioural
//            memory, randomized host/core/sink stimulus and a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_io_sequencer;

   localparam int DATA_W     = 16;
   localparam int ADDR_W     = 8;
   localparam int LOAD_WORDS = 4;
   localparam int DUMP_BASE  = 2;
   localparam int DUMP_WORDS = 3;
   localparam int NUM_CORES  = 4;
   localparam int RD_LAT     = 2;
   localparam int MEM_DEPTH  = 1 << ADDR_W;
   localparam int SEL_HIST_OK = 72; // mem_sel sequence 1,0,2,0 in base 4

   logic                 clk = 1'b0;
   logic                 RESET;
   logic                 go;
   logic                 din_valid;
   logic                 din_ready;
   logic [DATA_W-1:0]    din_data;
   logic [1:0]           mem_sel;
   logic [ADDR_W-1:0]    mem_addr;
   logic [DATA_W-1:0]    mem_wdata;
   logic                 mem_we;
   logic [DATA_W-1:0]    mem_rdata;
   logic [NUM_CORES-1:0] core_start;
   logic [NUM_CORES-1:0] core_end;
   logic                 dout_valid;
   logic                 dout_ready;
   logic [DATA_W-1:0]    dout_data;
   logic                 busy;
   logic                 done;
   logic [2:0]           state_disp;
`ifdef MEM_IO_CHECKSUM_EN
   logic [DATA_W-1:0]    checksum;
   logic                 checksum_valid;
`endif

   mem_io_sequencer #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .LOAD_WORDS(LOAD_WORDS),
      .DUMP_BASE(DUMP_BASE), .DUMP_WORDS(DUMP_WORDS),
      .NUM_CORES(NUM_CORES), .RD_LAT(RD_LAT)
   ) dut (
      .clk(clk), .RESET(RESET), .go(go),
      .din_valid(din_valid), .din_ready(din_ready), .din_data(din_data),
      .mem_sel(mem_sel), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_we(mem_we), .mem_rdata(mem_rdata),
      .core_start(core_start), .core_end(core_end),
      .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_data(dout_data),
      .busy(busy), .done(done), .state_disp(state_disp)
`ifdef MEM_IO_CHECKSUM_EN
      , .checksum(checksum), .checksum_valid(checksum_valid)
`endif
   );

   always #5 clk = ~clk;

   // ---------------- environment memory (RD_LAT pipeline) ----------------
   logic [DATA_W-1:0] mem     [0:MEM_DEPTH-1];
   logic [DATA_W-1:0] rd_pipe [0:RD_LAT-1];
   assign mem_rdata = rd_pipe[RD_LAT-1];

   // Memory writes only while the loader owns the port; reads are pipelined.
   always @(posedge clk) begin
      if (mem_we && mem_sel == 2'd1) mem[mem_addr] <= mem_wdata;
      rd_pipe[0] <= mem[mem_addr];
      for (int k = 1; k < RD_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
   end

   // ---------------- reference model and scoreboard state ----------------
   logic [DATA_W-1:0]    model_mem [0:MEM_DEPTH-1];
   logic [DATA_W-1:0]    sent      [0:LOAD_WORDS-1];
   logic [DATA_W-1:0]    exp_dump  [0:DUMP_WORDS-1];
   int                   end_dly   [0:NUM_CORES-1];
   logic [NUM_CORES-1:0] end_pulse;
   int n_checks = 0;
   int n_errs   = 0;
   int cyc = 0, wr_idx = 0, dump_idx = 0, start_cnt = 0, sel_hist = 0;
   int start_cyc = -1, sel2_cyc = -1, cur_maxd = 0, stall_target = 0;
   logic [1:0] prev_sel = 2'd0;
   logic prev_valid = 1'b0, prev_ready = 1'b0;
   logic [DATA_W-1:0] prev_data = '0;
   bit load_abort = 1'b0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errs++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Monitor: checks every write, start pulse and dump handshake mid-cycle.
   always @(negedge clk) begin
      #3;
      cyc++;
      if (mem_we) begin
         check_eq("wr_sel", mem_sel, 1);
         check_eq("wr_addr", mem_addr, wr_idx);
         if (wr_idx < LOAD_WORDS) check_eq("wr_data", mem_wdata, sent[wr_idx]);
         wr_idx++;
      end
      if (core_start != '0) begin
         check_eq("start_mask", core_start, {NUM_CORES{1'b1}});
         start_cnt++;
         start_cyc = cyc;
      end
      if (mem_sel != prev_sel) begin
         sel_hist = sel_hist * 4 + int'(mem_sel);
         if (mem_sel == 2'd2 && sel2_cyc < 0) sel2_cyc = cyc;
         prev_sel = mem_sel;
      end
      if (dout_valid && prev_valid && !prev_ready) check_eq("dout_stable", dout_data, prev_data);
      if (dout_valid && dout_ready) begin
         if (dump_idx < DUMP_WORDS) check_eq("dout_data", dout_data, exp_dump[dump_idx]);
         dump_idx++;
      end
      prev_valid = dout_valid;
      prev_ready = dout_ready;
      prev_data  = dout_data;
   end

   // Sink: holds dout_ready low stall_target cycles for each presented word.
   initial begin
      int stall_cnt;
      stall_cnt  = 0;
      dout_ready = 1'b0;
      forever begin
         @(negedge clk);
         if (!dout_valid) begin
            stall_cnt  = 0;
            dout_ready = 1'b0;
         end else if (stall_cnt >= stall_target) begin
            dout_ready = 1'b1;
         end else begin
            dout_ready = 1'b0;
            stall_cnt++;
         end
      end
   end

   // Host: gapmode 0 continuous, 1 alternating, 2 random valid.
   task automatic drive_load(input int gapmode);
      int i, t;
      logic v;
      i = 0;
      t = 0;
      while (i < LOAD_WORDS && t < 500 && !load_abort) begin
         @(negedge clk);
         case (gapmode)
            0:       v = 1'b1;
            1:       v = (t % 2 == 0);
            default: v = 1'($urandom_range(0, 1));
         endcase
         din_valid = v;
         din_data  = v ? sent[i] : DATA_W'($urandom);
         t++;
         #1;
         if (din_valid && din_ready) i++;
      end
      if (!load_abort) begin
         check_eq("load_handshakes", i, LOAD_WORDS);
         @(negedge clk);
         din_valid = 1'b1;
         din_data  = DATA_W'($urandom);
         #1;
         check_eq("din_ready_drop", din_ready, 0);
         @(negedge clk);
      end
      din_valid = 1'b0;
   endtask

   // Cores: each core ends end_dly cycles after the start cycle, pulse or level.
   task automatic drive_ends();
      bit found;
      found = 1'b0;
      for (int w = 0; w < 300; w++) begin
         @(negedge clk);
         #1;
         if (core_start != '0) begin
            found = 1'b1;
            break;
         end
      end
      if (!found) begin
         check_eq("start_timeout", 0, 1);
         return;
      end
      for (int k = 0; k <= cur_maxd + 1; k++) begin
         if (k > 0) begin
            @(negedge clk);
            #1;
         end
         for (int c = 0; c < NUM_CORES; c++)
            core_end[c] = end_pulse[c] ? (k == end_dly[c]) : (k >= end_dly[c]);
      end
      core_end = '0;
   endtask

   // Pulses go while LOAD and DUMP_OUT are active; both must be ignored.
   task automatic go_glitch();
      bit found;
      found = 1'b0;
      for (int w = 0; w < 100 && !found; w++) begin
         @(negedge clk);
         #1;
         if (state_disp == 3'd1) found = 1'b1;
      end
      check_eq("glitch_load_seen", found, 1);
      go = 1'b1;
      @(negedge clk);
      go = 1'b0;
      found = 1'b0;
      for (int w = 0; w < 3000 && !found; w++) begin
         @(negedge clk);
         #1;
         if (state_disp == 3'd6) found = 1'b1;
      end
      check_eq("glitch_dump_seen", found, 1);
      go = 1'b1;
      @(negedge clk);
      go = 1'b0;
   endtask

   task automatic check_reset_state(input string pfx);
      check_eq({pfx, "_we"},         mem_we, 0);
      check_eq({pfx, "_sel"},        mem_sel, 0);
      check_eq({pfx, "_addr"},       mem_addr, 0);
      check_eq({pfx, "_wdata"},      mem_wdata, 0);
      check_eq({pfx, "_core_start"}, core_start, 0);
      check_eq({pfx, "_dout_valid"}, dout_valid, 0);
      check_eq({pfx, "_dout_data"},  dout_data, 0);
      check_eq({pfx, "_din_ready"},  din_ready, 0);
      check_eq({pfx, "_busy"},       busy, 0);
      check_eq({pfx, "_done"},       done, 0);
      check_eq({pfx, "_state"},      state_disp, 0);
   endtask

   task automatic prepare_seq();
      int a;
      cur_maxd = 0;
      for (int c = 0; c < NUM_CORES; c++) if (end_dly[c] > cur_maxd) cur_maxd = end_dly[c];
      for (int j = 0; j < DUMP_WORDS; j++) begin
         a = DUMP_BASE + j;
         exp_dump[j] = (a < LOAD_WORDS) ? sent[a] : model_mem[a];
      end
      wr_idx = 0; dump_idx = 0; start_cnt = 0; sel_hist = 0;
      start_cyc = -1; sel2_cyc = -1; load_abort = 1'b0;
      @(negedge clk);
      go = 1'b1;
      @(negedge clk);
      go = 1'b0;
   endtask

   task automatic run_seq(input int gapmode, input int stall, input bit glitch);
      bit   found;
      int   lag;
      logic [DATA_W-1:0] sum;
      stall_target = stall;
      prepare_seq();
      fork
         drive_load(gapmode);
         drive_ends();
         begin
            if (glitch) go_glitch();
         end
      join
      found = 1'b0;
      for (int w = 0; w < 3000 && !found; w++) begin
         @(negedge clk);
         #1;
         if (done) found = 1'b1;
      end
      check_eq("done_timeout", found, 1);
      #4;
      sum = '0;
      for (int j = 0; j < DUMP_WORDS; j++) sum = sum + exp_dump[j];
      lag = sel2_cyc - start_cyc;
      check_eq("busy_in_done", busy, 0);
      check_eq("state_done", state_disp, 7);
      check_eq("sel_in_done", mem_sel, 0);
      check_eq("din_ready_done", din_ready, 0);
      check_eq("write_count", wr_idx, LOAD_WORDS);
      check_eq("dump_count", dump_idx, DUMP_WORDS);
      check_eq("start_count", start_cnt, 1);
      check_eq("sel_sequence", sel_hist, SEL_HIST_OK);
      check_eq("dump_after_ends", (lag > cur_maxd) && (lag <= cur_maxd + 3), 1);
`ifdef MEM_IO_CHECKSUM_EN
      check_eq("checksum", checksum, sum);
      check_eq("checksum_valid", checksum_valid, 1);
`endif
      repeat (3) @(negedge clk);
      #4;
      check_eq("done_hold", done, 1);
      for (int i = 0; i < LOAD_WORDS; i++) model_mem[i] = sent[i];
   endtask

   // Watchdog against a hung sequence.
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit found;
      for (int i = 0; i < MEM_DEPTH; i++) begin
         mem[i]       = DATA_W'(i + 100);
         model_mem[i] = DATA_W'(i + 100);
      end
      for (int k = 0; k < RD_LAT; k++) rd_pipe[k] = '0;
      RESET = 1'b0; go = 1'b0; din_valid = 1'b0; din_data = '0; core_end = '0;
      repeat (3) @(negedge clk);
      #4;
      check_reset_state("por");
      RESET = 1'b1;

      // Directed: data 5..8, continuous valid, 5-cycle sink stalls,
      // ends at 3,10,10,25 with cores 2 and 3 pulsed.
      for (int i = 0; i < LOAD_WORDS; i++) sent[i] = DATA_W'(i + 5);
      end_dly[0] = 3; end_dly[1] = 10; end_dly[2] = 10; end_dly[3] = 25;
      end_pulse = 4'b1100;
      run_seq(0, 5, 1'b0);
      // Go from DONE repeats the identical sequence, with ignored go pulses.
      run_seq(0, 5, 1'b1);
      // Alternating din_valid.
      run_seq(1, 0, 1'b0);

      // Randomized sequences.
      for (int r = 0; r < 5; r++) begin
         for (int i = 0; i < LOAD_WORDS; i++) sent[i] = DATA_W'($urandom);
         for (int c = 0; c < NUM_CORES; c++) end_dly[c] = $urandom_range(0, 30);
         end_pulse = NUM_CORES'($urandom);
         run_seq($urandom_range(0, 2), $urandom_range(0, 4), 1'($urandom_range(0, 1)));
      end

      // Reset in the middle of a load, then a full sequence from address 0.
      for (int i = 0; i < LOAD_WORDS; i++) sent[i] = DATA_W'($urandom);
      stall_target = 0;
      prepare_seq();
      fork
         drive_load(1);
         begin
            found = 1'b0;
            for (int w = 0; w < 200 && !found; w++) begin
               @(negedge clk);
               #4;
               if (wr_idx >= 2) found = 1'b1;
            end
            check_eq("abort_two_writes", found, 1);
            @(negedge clk);
            #2;
            RESET = 1'b0;
            load_abort = 1'b1;
            #1;
            check_reset_state("abort");
            @(negedge clk);
            @(negedge clk);
            RESET = 1'b1;
         end
      join
      for (int i = 0; i < LOAD_WORDS; i++) sent[i] = DATA_W'($urandom);
      for (int c = 0; c < NUM_CORES; c++) end_dly[c] = $urandom_range(0, 30);
      end_pulse = NUM_CORES'($urandom);
      run_seq(2, 2, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
